// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage: instruction-fetch stage plus IF/ID pipeline register.
//   Holds the fetch PC and drives the instruction-memory address. Captures the
//   fetched word into IF/ID, or inserts a NOP bubble when ID asks for it.
//   Accepts stall, flush and redirect requests from the decode stage.
// Ports:
//   clk, reset (async, active-low)
//   stall_i, flush_i, redirect_i, redirect_pc_i       : control from ID
//   imem_addr_o / imem_rdata_i                        : zero-wait instruction memory
//   pc_f_o                                            : current fetch PC
//   id_valid_o, id_instr_o, id_pc_o, id_pcplus4_o     : IF/ID register contents
//   id_opcode_o .. id_imm12_o                         : field slices of id_instr_o
//   fetch_cnt_o                                       : valid instructions written to IF/ID
// ---------------------------------------------------------------------------
module if_stage #(
    parameter int unsigned     ADDR_WIDTH = 32,
    parameter logic [31:0]     RESET_PC   = 32'h0000_0000,
    parameter logic [31:0]     NOP_INSTR  = 32'h0000_0013
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall_i,
    input  logic                  flush_i,
    input  logic                  redirect_i,
    input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
    output logic [ADDR_WIDTH-1:0] imem_addr_o,
    input  logic [31:0]           imem_rdata_i,
    output logic [ADDR_WIDTH-1:0] pc_f_o,
    output logic                  id_valid_o,
    output logic [31:0]           id_instr_o,
    output logic [ADDR_WIDTH-1:0] id_pc_o,
    output logic [ADDR_WIDTH-1:0] id_pcplus4_o,
    output logic [6:0]            id_opcode_o,
    output logic [2:0]            id_funct3_o,
    output logic [6:0]            id_funct7_o,
    output logic [4:0]            id_rd_o,
    output logic [4:0]            id_rs1_o,
    output logic [4:0]            id_rs2_o,
    output logic [11:0]           id_imm12_o,
    output logic [31:0]           fetch_cnt_o
);

    localparam int unsigned CNT_W = 32;

    logic [ADDR_WIDTH-1:0] pc_q,        pc_d;
    logic                  id_valid_q,  id_valid_d;
    logic [31:0]           id_instr_q,  id_instr_d;
    logic [ADDR_WIDTH-1:0] id_pc_q,     id_pc_d;
    logic [ADDR_WIDTH-1:0] id_pcp4_q,   id_pcp4_d;
    logic [CNT_W-1:0]      fetch_cnt_q, fetch_cnt_d;

    logic [ADDR_WIDTH-1:0] pc_plus4;
    logic                  redirect_lsb_unused;

    // Target alignment drops the low two bits; they are deliberately ignored.
    assign redirect_lsb_unused = ^redirect_pc_i[1:0];

    assign pc_plus4 = pc_q + ADDR_WIDTH'(4);

    // Next-PC selection: stall holds, redirect wins over sequential fetch.
    always_comb begin
        pc_d = pc_q;
        if (stall_i) begin
            pc_d = pc_q;
        end else if (redirect_i) begin
            pc_d = {redirect_pc_i[ADDR_WIDTH-1:2], 2'b00};
        end else begin
            pc_d = pc_plus4;
        end
    end

    // IF/ID update: flush beats stall; a redirect kills the wrong-path fetch.
    always_comb begin
        id_valid_d  = id_valid_q;
        id_instr_d  = id_instr_q;
        id_pc_d     = id_pc_q;
        id_pcp4_d   = id_pcp4_q;
        fetch_cnt_d = fetch_cnt_q;
        if (flush_i) begin
            id_valid_d = 1'b0;
            id_instr_d = NOP_INSTR;
        end else if (stall_i) begin
            id_valid_d = id_valid_q;
        end else if (redirect_i) begin
            id_valid_d = 1'b0;
            id_instr_d = NOP_INSTR;
        end else begin
            id_valid_d  = 1'b1;
            id_instr_d  = imem_rdata_i;
            id_pc_d     = pc_q;
            id_pcp4_d   = pc_plus4;
            fetch_cnt_d = fetch_cnt_q + CNT_W'(1);
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q        <= RESET_PC[ADDR_WIDTH-1:0];
            id_valid_q  <= 1'b0;
            id_instr_q  <= NOP_INSTR;
            id_pc_q     <= '0;
            id_pcp4_q   <= ADDR_WIDTH'(4);
            fetch_cnt_q <= '0;
        end else begin
            pc_q        <= pc_d;
            id_valid_q  <= id_valid_d;
            id_instr_q  <= id_instr_d;
            id_pc_q     <= id_pc_d;
            id_pcp4_q   <= id_pcp4_d;
            fetch_cnt_q <= fetch_cnt_d;
        end
    end

    assign imem_addr_o  = pc_q;
    assign pc_f_o       = pc_q;
    assign id_valid_o   = id_valid_q;
    assign id_instr_o   = id_instr_q;
    assign id_pc_o      = id_pc_q;
    assign id_pcplus4_o = id_pcp4_q;
    assign fetch_cnt_o  = fetch_cnt_q;

    // Decode fields are plain slices of the registered instruction word.
    assign id_opcode_o  = id_instr_q[6:0];
    assign id_rd_o      = id_instr_q[11:7];
    assign id_funct3_o  = id_instr_q[14:12];
    assign id_rs1_o     = id_instr_q[19:15];
    assign id_rs2_o     = id_instr_q[24:20];
    assign id_funct7_o  = id_instr_q[31:25];
    assign id_imm12_o   = id_instr_q[31:20];

endmodule
